// File: rtl/result_display.sv
// result_display: fetches four pooled results from the result buffer and scans them as hex on an 8-digit 7-segment display
module result_display #(
  parameter int REFRESH_DIV = 100000,
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       rd_en,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       loaded,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int CW = $clog2(REFRESH_DIV);
  typedef enum logic [1:0] {IDLE, FETCH, SHOW} state_t;
  state_t state, state_n;
  logic [2:0] fc, fc_n, dig, dig_n;
  logic [CW-1:0] rcnt, rcnt_n;
  logic [3:0][7:0] r, r_n;
  logic rd_en_n, loaded_n, tc;
  logic [7:0] rd_addr_n, an_n;
  logic [6:0] seg_n;
  logic [3:0] nib;
  function automatic logic [6:0] font(input logic [3:0] h);
    case (h)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      default: font = 7'h0E;
    endcase
  endfunction
  assign tc = rcnt == CW'(REFRESH_DIV - 1);
  always_comb begin
    state_n = state;
    fc_n = fc;
    dig_n = 3'd0;
    rcnt_n = '0;
    r_n = r;
    rd_en_n = 1'b0;
    rd_addr_n = rd_addr;
    loaded_n = 1'b0;
    an_n = 8'hFF;
    seg_n = 7'h7F;
    nib = 4'd0;
    if (state == IDLE) begin
      if (enable) begin
        state_n = FETCH;
        fc_n = 3'd0;
        rd_en_n = 1'b1;
        rd_addr_n = BASE_ADDR;
      end
    end else if (!enable) begin
      state_n = IDLE;
    end else if (state == FETCH) begin
      fc_n = fc + 3'd1;
      rd_en_n = fc < 3'd3;
      if (fc < 3'd3) rd_addr_n = BASE_ADDR + {5'd0, fc} + 8'd1;
      if (fc != 3'd0) r_n[fc[1:0] - 2'd1] = rd_data;
      if (fc == 3'd4) begin
        state_n = SHOW;
        loaded_n = 1'b1;
      end
    end else begin
      rcnt_n = tc ? '0 : rcnt + CW'(1);
      dig_n = tc ? dig + 3'd1 : dig;
    end
    if (state_n == SHOW) begin
      nib = dig_n[0] ? r_n[dig_n[2:1]][7:4] : r_n[dig_n[2:1]][3:0];
      an_n = ~(8'd1 << dig_n);
      seg_n = font(nib);
    end
  end
  always_ff @(posedge clk) begin
    dp <= 1'b1;
    if (rst) begin
      state <= IDLE;
      fc <= 3'd0;
      dig <= 3'd0;
      rcnt <= '0;
      r <= '0;
      rd_en <= 1'b0;
      rd_addr <= BASE_ADDR;
      loaded <= 1'b0;
      an <= 8'hFF;
      seg <= 7'h7F;
    end else begin
      state <= state_n;
      fc <= fc_n;
      dig <= dig_n;
      rcnt <= rcnt_n;
      r <= r_n;
      rd_en <= rd_en_n;
      rd_addr <= rd_addr_n;
      loaded <= loaded_n;
      an <= an_n;
      seg <= seg_n;
    end
  end
endmodule

// File: tb/tb_result_display.sv
// tb_result_display: directed bench with read-address scoreboard for two result_display instances
module tb_result_display;
  logic clk = 1'b0;
  logic rst, en_a, en_b;
  logic rd_en_a, rd_en_b, loaded_a, loaded_b, dp_a, dp_b;
  logic [7:0] rd_addr_a, rd_addr_b, an_a, an_b;
  logic [7:0] rd_data_a = 8'h00, rd_data_b = 8'h00;
  logic [6:0] seg_a, seg_b;
  logic [7:0] mem [256];
  logic [7:0] q_a[$], q_b[$];
  int total = 0, bad = 0, nrd_a = 0, nrd_b = 0;
  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  always #5 clk = ~clk;
  result_display #(.REFRESH_DIV(4), .BASE_ADDR(8'h00)) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .loaded(loaded_a), .an(an_a), .seg(seg_a), .dp(dp_a)
  );
  result_display #(.REFRESH_DIV(4), .BASE_ADDR(8'h10)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .loaded(loaded_b), .an(an_b), .seg(seg_b), .dp(dp_b)
  );
  // read port: data valid only in the cycle after a strobe, junk otherwise
  always @(posedge clk) begin
    rd_data_a <= rd_en_a ? mem[rd_addr_a] : 8'($urandom);
    rd_data_b <= rd_en_b ? mem[rd_addr_b] : 8'($urandom);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rd_en_a) begin
      nrd_a++;
      if (q_a.size() == 0) chk("rd_a_unexpected", {24'd0, rd_addr_a}, 32'hFFFF_FFFF);
      else chk("rd_addr_a", {24'd0, rd_addr_a}, {24'd0, q_a.pop_front()});
    end
    if (rd_en_b) begin
      nrd_b++;
      if (q_b.size() == 0) chk("rd_b_unexpected", {24'd0, rd_addr_b}, 32'hFFFF_FFFF);
      else chk("rd_addr_b", {24'd0, rd_addr_b}, {24'd0, q_b.pop_front()});
    end
  end
  task automatic wait_loaded(input bit b, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(b ? loaded_b : loaded_a) && n < 20);
    chk(tag, n, 6);
  endtask
  task automatic show_check(input bit b, input string tag, input logic [31:0] data);
    logic [7:0] ea;
    for (int d = 0; d < 8; d++)
      for (int c = 0; c < 4; c++) begin
        ea = ~(8'd1 << d);
        chk({tag, "_an"}, b ? an_b : an_a, {24'd0, ea});
        chk({tag, "_seg"}, b ? seg_b : seg_a, {25'd0, font[data[d*4 +: 4]]});
        chk({tag, "_loaded"}, b ? loaded_b : loaded_a, (d == 0 && c == 0) ? 1 : 0);
        @(negedge clk);
      end
    chk({tag, "_wrap"}, b ? an_b : an_a, 32'hFE);
  endtask
  task automatic blank_check(input string tag);
    chk({tag, "_an"}, an_a, 32'hFF);
    chk({tag, "_seg"}, seg_a, 32'h7F);
    chk({tag, "_rd_en"}, rd_en_a, 0);
    chk({tag, "_loaded"}, loaded_a, 0);
    chk({tag, "_dp"}, dp_a, 1);
  endtask
  initial begin
    foreach (mem[i]) mem[i] = 8'(i * 7 + 3);
    {mem[0], mem[1], mem[2], mem[3]} = 32'h1234ABF0;
    {mem[16], mem[17], mem[18], mem[19]} = 32'h00FF807F;
    rst = 1'b1;
    en_a = 1'b0;
    en_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    blank_check("reset");
    chk("reset_addr_a", rd_addr_a, 32'h00);
    chk("reset_addr_b", rd_addr_b, 32'h10);
    chk("reset_an_b", an_b, 32'hFF);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      blank_check("idle");
    end
    en_a = 1'b1;
    for (int i = 0; i < 4; i++) q_a.push_back(8'(i));
    wait_loaded(0, "load_latency");
    chk("load_reads", nrd_a, 4);
    show_check(0, "scan", 32'hF0AB3412);
    en_a = 1'b0;
    repeat (2) begin
      @(negedge clk);
      blank_check("disable");
    end
    en_a = 1'b1;
    q_a.push_back(8'h00);
    q_a.push_back(8'h01);
    repeat (2) @(negedge clk);
    en_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      blank_check("abort");
    end
    chk("abort_reads", nrd_a, 6);
    {mem[0], mem[1], mem[2], mem[3]} = 32'h9CE7012D;
    en_a = 1'b1;
    for (int i = 0; i < 4; i++) q_a.push_back(8'(i));
    wait_loaded(0, "refetch_latency");
    show_check(0, "refetch", 32'h2D01E79C);
    repeat (20) @(negedge clk);
    chk("digit5_an", an_a, 32'hDF);
    rst = 1'b1;
    mem[0] = 8'h5E;
    @(negedge clk);
    blank_check("show_reset");
    chk("show_reset_addr", rd_addr_a, 32'h00);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) q_a.push_back(8'(i));
    wait_loaded(0, "rst_refetch_latency");
    chk("rst_refetch_an", an_a, 32'hFE);
    chk("rst_refetch_seg", seg_a, {25'd0, font[4'hE]});
    chk("rst_refetch_reads", nrd_a, 14);
    en_b = 1'b1;
    for (int i = 0; i < 4; i++) q_b.push_back(8'(8'h10 + i));
    wait_loaded(1, "base_latency");
    show_check(1, "base", 32'h7F80FF00);
    chk("base_reads", nrd_b, 4);
    chk("queue_a_empty", q_a.size(), 0);
    chk("queue_b_empty", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/result_display.md
# result_display

Reader side of the result buffer. Once the phase controller releases the display stage by raising `enable` in its final phase, this block fetches the four 8-bit pooled results from the result buffer over a 1-cycle-latency read port. It latches them and drives an 8-digit multiplexed 7-segment display with them as hex. It is the last block in the processing chain.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal ≥ 2.
- `BASE_ADDR`, default 8'h00: buffer address of result 0; results occupy `BASE_ADDR`..`BASE_ADDR+3`.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  level; 1 = display stage released (driven by controller display-release line).
- `rd_en`  out  1  read strobe to result buffer.
- `rd_addr`  out  8  read address.
- `rd_data`  in  8  read data, valid exactly 1 cycle after the cycle `rd_en`=1.
- `loaded`  out  1  one-cycle pulse when all 4 results are latched.
- `an`  out  8  digit anodes, active-low, one-hot-low while showing; `an[0]` = rightmost digit.
- `seg`  out  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- `dp`  out  1  decimal point, active-low; held 1 (off).

## Operation
- All outputs are registered.
- Reset values: `rd_en`=0, `rd_addr`=`BASE_ADDR`, `loaded`=0, `an`=8'hFF, `seg`=7'h7F, `dp`=1.
- Internal reset values: state IDLE, result regs R0..R3=0, refresh counter=0, digit index=0.
- State machine:
  - IDLE: display blank (`an`=FF, `seg`=7F). `enable`=1 → FETCH.
  - FETCH: issues 4 reads at consecutive cycles, addresses `BASE_ADDR`+0..3. Captures `rd_data` into R0..R3 one cycle after each read. The cycle after the capture of R3, moves to SHOW and pulses `loaded`.
  - SHOW: refresh counter counts 0..`REFRESH_DIV`-1. At terminal count it wraps to 0 and the digit index advances mod 8 (7→0).
- Digit mapping:
  - Digit d drives `an[d]`=0, all other anodes 1.
  - Displayed nibble = R[d/2] low nibble for even d, high nibble for odd d.
  - So R0 appears on the rightmost pair, high nibble on the left.
- Hex font (active-low gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- `enable` falling in FETCH or SHOW:
  - Next state IDLE, `rd_en`=0, display blanks, refresh counter and digit index clear.
  - R0..R3 are retained but not shown.
  - The next `enable` rise refetches all four results; stale values are never displayed.
- `enable` is not edge-detected: holding it high keeps SHOW indefinitely. The block never refetches without passing through IDLE.
- `rst`=1 has priority over everything, including mid-FETCH (aborts reads) and SHOW.

## Timing
- Let E0 be the edge at which IDLE samples `enable`=1.
- Read issue:
  - After E0: `rd_en`=1, `rd_addr`=`BASE_ADDR`.
  - After E1, E2, E3: addresses +1, +2, +3.
  - After E4: `rd_en`=0, `rd_addr` holds the last value.
- Data capture:
  - R0 is captured at E2, R1 at E3, R2 at E4, R3 at E5.
  - `rd_data` is sampled only on those edges.
- Display start:
  - After E5: state SHOW, `loaded`=1 for exactly one cycle.
  - `an`=8'hFE and `seg`=font(R0[3:0]) in the same cycle.
- Load latency: 6 cycles from the `enable` sample to the first lit digit.
- Digit cadence: digit index changes every `REFRESH_DIV` cycles. The first change occurs `REFRESH_DIV` cycles after SHOW entry.
- `an`/`seg` change on the same edge; there is no blanking gap between digits.
- `enable` deasserted at edge Ex: outputs blank after Ex. A `loaded` pulse already scheduled for that cycle is suppressed.

## Test plan
1. **Reset and idle.** `rst`=1 for 2 cycles with `enable`=0 → `an`=FF, `seg`=7F, `dp`=1, `rd_en`=0, `loaded`=0; outputs hold for 100 cycles.
2. **Nominal load.**
   - Stimulus: buffer holds {12,34,AB,F0} at addr 0..3; `REFRESH_DIV`=4; raise `enable`.
   - `rd_en` is high exactly 4 cycles with addr 0,1,2,3.
   - `loaded` pulses 6 cycles after the `enable` sample.
   - First digit: `an`=FE, `seg`=24 ('2').
3. **Digit scan.** Continue test 2 → every 4 cycles the `an` sequence FE,FD,FB,F7,EF,DF,BF,7F,FE. Required `seg` sequence: 24,79,19,30,03,08,40,0E.
4. **Abort mid-fetch.**
   - Drop `enable` after the 2nd read → `rd_en`=0 next cycle, no `loaded`, display blank.
   - Re-raise → 4 fresh reads from addr 0 and correct display.
5. **Reset during SHOW.** `rst`=1 for 1 cycle while digit 5 is lit → all outputs at reset values next cycle. With `enable` still 1 after reset, a full refetch occurs (4 reads, `loaded` pulse).
6. **Nonzero base.** `BASE_ADDR`=8'h10 with data 00,FF,80,7F at 10..13 → `rd_addr` sequence 10,11,12,13. Digits right-to-left: 0,0,F,F,0,8,F,7.
